// File: rtl/seg7_capture_decoder_pkg.sv
// Shared constants for the seven-segment reader: segment patterns, symbol codes, output FSM states.
// Build option: define SEG7_CAPTURE_DP_EN to carry the decimal point (8-bit bus, 6-bit codes).
package seg7_pkg;

`ifdef SEG7_CAPTURE_DP_EN
    localparam int SEG_W  = 8;
    localparam int CODE_W = 6;
`else
    localparam int SEG_W  = 7;
    localparam int CODE_W = 5;
`endif

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] SEG_PLUS  = 7'b0001100;
    localparam logic [6:0] SEG_EQUAL = 7'b1110110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [4:0] SYM_PLUS    = 5'd16;
    localparam logic [4:0] SYM_EQUAL   = 5'd17;
    localparam logic [4:0] SYM_BLANK   = 5'd18;
    localparam logic [4:0] SYM_INVALID = 5'd31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } out_state_e;

endpackage

// File: rtl/seg7_capture_decoder_pattern_decode.sv
// Combinational segment pattern -> symbol code lookup; unknown patterns map to SYM_INVALID.
// With SEG7_CAPTURE_DP_EN the lit decimal point is appended as the code MSB.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]  i_seg,
    output logic [CODE_W-1:0] o_code
);

    logic [4:0] w_sym;

    always_comb begin
        w_sym = SYM_INVALID;
        for (int k = 0; k < 16; k++) begin
            if (i_seg[6:0] == SEG_HEX[k]) w_sym = 5'(k);
        end
        if (i_seg[6:0] == SEG_PLUS)  w_sym = SYM_PLUS;
        if (i_seg[6:0] == SEG_EQUAL) w_sym = SYM_EQUAL;
        if (i_seg[6:0] == SEG_BLANK) w_sym = SYM_BLANK;
    end

`ifdef SEG7_CAPTURE_DP_EN
    assign o_code = {~i_seg[7], w_sym};
`else
    assign o_code = w_sym;
`endif

endmodule

// File: rtl/seg7_capture_decoder.sv
// Seven-segment bus reader: debounces the multiplexed bus, keeps a per-digit symbol store
// and streams change events. Build option SEG7_CAPTURE_DP_EN adds the decimal point bit.
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS    = 6,
    parameter  int STABLE_CYCLES = 4,
    localparam int IDX_W         = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SEG_W-1:0]             seg_in,
    input  logic [NUM_DIGITS-1:0]        dig_sel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_digit,
    output logic [CODE_W-1:0]            out_code,
    output logic [CODE_W*NUM_DIGITS-1:0] digits_flat,
    output logic [NUM_DIGITS-1:0]        err_flags
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [SEG_W-1:0]                   r_seg, r_seg_prev;
    logic [NUM_DIGITS-1:0]              r_dig, r_dig_prev;
    logic [7:0]                         r_cnt;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]  r_store;
    logic [NUM_DIGITS-1:0]              r_err;
    logic [NUM_DIGITS-1:0]              r_dirty;
    out_state_e                         r_state;
    logic [IDX_W-1:0]                   r_out_digit;
    logic [CODE_W-1:0]                  r_out_code;

    logic                  w_onehot, w_same, w_cap, w_changed, w_any_dirty, w_load;
    logic [IDX_W-1:0]      w_cap_idx, w_pick_idx;
    logic [CODE_W-1:0]     w_code;
    logic [NUM_DIGITS-1:0] w_set_mask, w_clr_mask;

    seg7_pattern_decode u_decode (
        .i_seg  (r_seg),
        .o_code (w_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= '1;
            r_seg_prev <= '1;
            r_dig      <= '0;
            r_dig_prev <= '0;
        end else begin
            r_seg      <= seg_in;
            r_dig      <= dig_sel;
            r_seg_prev <= r_seg;
            r_dig_prev <= r_dig;
        end
    end

    assign w_onehot = (r_dig != '0) && ((r_dig & (r_dig - NUM_DIGITS'(1))) == '0);
    assign w_same   = (r_seg == r_seg_prev) && (r_dig == r_dig_prev);
    // Capture exactly once, on the step into saturation
    assign w_cap    = w_same && w_onehot && (r_cnt == CNT_MAX - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_cnt <= '0;
        else if (!(w_same && w_onehot)) r_cnt <= '0;
        else if (r_cnt != CNT_MAX)  r_cnt <= r_cnt + 8'd1;
    end

    always_comb begin
        w_cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_dig[i]) w_cap_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_pick_idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_dirty[i]) w_pick_idx = IDX_W'(i);
        end
    end

    assign w_changed   = (w_code != r_store[w_cap_idx]);
    assign w_any_dirty = |r_dirty;
    assign w_load      = w_any_dirty && ((r_state == ST_IDLE) || out_ready);
    assign w_set_mask  = (w_cap && w_changed) ? (NUM_DIGITS'(1) << w_cap_idx) : '0;
    assign w_clr_mask  = w_load ? (NUM_DIGITS'(1) << w_pick_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_store[i] <= CODE_W'(SYM_BLANK);
            r_err <= '0;
        end else if (w_cap) begin
            r_store[w_cap_idx] <= w_code;
            r_err[w_cap_idx]   <= (w_code[4:0] == SYM_INVALID);
        end
    end

    // A capture landing on the index being cleared re-arms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dirty <= '0;
        else        r_dirty <= (r_dirty & ~w_clr_mask) | w_set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_digit <= '0;
            r_out_code  <= '0;
        end else begin
            if (w_load) begin
                r_out_digit <= w_pick_idx;
                r_out_code  <= r_store[w_pick_idx];
                r_state     <= ST_PEND;
            end else if (r_state == ST_PEND && out_ready) begin
                r_state     <= ST_IDLE;
            end
        end
    end

    assign out_valid   = (r_state == ST_PEND);
    assign out_digit   = r_out_digit;
    assign out_code    = r_out_code;
    assign digits_flat = r_store;
    assign err_flags   = r_err;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder with an event scoreboard queue.
module tb_seg7_capture_decoder;

    localparam int ND = 6;

    typedef struct packed {
        logic [2:0] d;
        logic [4:0] c;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_in = 7'h7f;
    logic [ND-1:0] dig_sel = '0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [2:0]    out_digit;
    logic [4:0]    out_code;
    logic [29:0]   digits_flat;
    logic [5:0]    err_flags;

    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];
    ev_t e_mon;

    seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_digit   (out_digit),
        .out_code    (out_code),
        .digits_flat (digits_flat),
        .err_flags   (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] slot(input int i);
        return digits_flat[5*i +: 5];
    endfunction

    task automatic hold(input logic [ND-1:0] d, input logic [6:0] s, input int n);
        dig_sel = d;
        seg_in  = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int c);
        exp_q.push_back(ev_t'{d: 3'(d), c: 5'(c)});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_event", 32'(out_valid), 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("ev_digit", 32'(out_digit), 32'(e_mon.d));
                chk("ev_code", 32'(out_code), 32'(e_mon.c));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < ND; i++) chk("rst_slot", 32'(slot(i)), 32'd18);
        chk("rst_err", 32'(err_flags), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_digit", 32'(out_digit), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        repeat (100) begin
            @(negedge clk);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Latency: capture at T+5, out_valid only after edge T+6, handshake at T+7
        push(2, 2);
        dig_sel = 6'b000100;
        seg_in  = 7'b0100100;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 5) chk("lat_slot2", 32'(slot(2)), 32'd2);
            chk("lat_valid", 32'(out_valid), 32'(k == 6));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("lat_drain", 32'(exp_q.size()), 32'd0);

        // Glitch: 3-cycle pattern must not capture
        push(0, 16);
        hold(6'b000001, 7'b1111001, 3);
        hold(6'b000001, 7'b0001100, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_slot0", 32'(slot(0)), 32'd16);
        chk("glitch_drain", 32'(exp_q.size()), 32'd0);

        // Backpressure ordering: event 0 held pending, then 3,1,5 drain as 1,3,5
        out_ready = 1'b0;
        hold(6'b000001, 7'b0011001, 6);
        hold(6'b001000, 7'b0110000, 6);
        hold(6'b000010, 7'b1111000, 6);
        hold(6'b100000, 7'b0001000, 6);
        push(0, 4); push(1, 7); push(3, 3); push(5, 10);
        chk("bp_slot3", 32'(slot(3)), 32'd3);
        chk("bp_slot1", 32'(slot(1)), 32'd7);
        chk("bp_slot5", 32'(slot(5)), 32'd10);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_digit", 32'(out_digit), 32'd0);
        chk("bp_hold_code", 32'(out_code), 32'd4);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Coalescing: digit 4 goes 7->8->9 undelivered; digit 0 re-dirtied while pending
        out_ready = 1'b0;
        hold(6'b000001, 7'b0010010, 6);
        hold(6'b010000, 7'b1111000, 6);
        hold(6'b010000, 7'b0000000, 6);
        hold(6'b010000, 7'b0010000, 6);
        hold(6'b000001, 7'b0000010, 6);
        push(0, 5); push(0, 6); push(4, 9);
        chk("co_hold_code", 32'(out_code), 32'd5);
        chk("co_slot4", 32'(slot(4)), 32'd9);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("co_done_valid", 32'(out_valid), 32'd0);
        chk("co_drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Invalid pattern sets and clears the error flag
        push(0, 31);
        hold(6'b000001, 7'b1010101, 6);
        repeat (2) @(posedge clk);
        #1;
        chk("inv_err", 32'(err_flags), 32'd1);
        chk("inv_slot0", 32'(slot(0)), 32'd31);
        push(0, 1);
        hold(6'b000001, 7'b1111001, 6);
        repeat (2) @(posedge clk);
        #1;
        chk("inv_err_clr", 32'(err_flags), 32'd0);
        chk("inv_slot0_1", 32'(slot(0)), 32'd1);
        chk("inv_drain", 32'(exp_q.size()), 32'd0);

        // Two strobe bits: nothing captured
        hold(6'b000011, 7'b1000000, 8);
        chk("multi_slot0", 32'(slot(0)), 32'd1);
        chk("multi_slot1", 32'(slot(1)), 32'd7);
        chk("multi_valid", 32'(out_valid), 32'd0);

        // Reset while an event is pending discards it immediately
        out_ready = 1'b0;
        hold(6'b000100, 7'b0000000, 6);
        repeat (2) @(posedge clk);
        #1;
        chk("pend_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < ND; i++) chk("arst_slot", 32'(slot(i)), 32'd18);
        chk("arst_err", 32'(err_flags), 32'd0);
        dig_sel = '0;
        seg_in  = 7'h7f;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
